hazard_fwd_unit: RTL and testbench

Parametrised hazard-detection and operand-forwarding unit for the pipelined CPU core. It tracks in-flight register writes in a DEPTH-entry shadow pipeline that advances in step with the datapath stage buffers. It drives RAW-forwarded operands to the EX stage, detects load-use hazards and generates stall, and squashes on taken branches. It also keeps saturating stall and flush counters for performance visibility.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/hazard_fwd_unit_if.sv | 44 ++++
 rtl/fwd_match_prio.sv | 44 ++++
 rtl/hazard_fwd_unit.sv | 97 +++++++++
 tb/tb_hazard_fwd_unit.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: shadow-pipeline entry layout, forward-select encoding and
// default datapath sizes reused by the register file, ALU and hazard unit.
package cpu_pkg;

  localparam int unsigned DW_DEFAULT   = 16;
  localparam int unsigned NREG_DEFAULT = 16;

  // Widest register address a shadow entry can hold; narrower addresses are zero-extended.
  localparam int unsigned RD_W = 8;

  // Forward-select value meaning "use the register file".
  localparam int unsigned FWD_RF = 0;

  // Forward-select value meaning "use the output of stage k".
  function automatic int unsigned FWD_STAGE(input int unsigned k);
    return k;
  endfunction

  typedef struct packed {
    logic            v;
    logic [RD_W-1:0] rd;
    logic            wen;
    logic            ld;
  } shadow_entry_t;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard/forwarding unit (slave).
interface hazard_fwd_unit_if #(
  parameter int unsigned DW    = 16,
  parameter int unsigned NREG  = 16,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CW    = 16
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(DEPTH + 1);

  logic                id_valid;
  logic [AW-1:0]       id_rs_addr;
  logic                id_rs_used;
  logic [AW-1:0]       id_rt_addr;
  logic                id_rt_used;
  logic [AW-1:0]       id_rd_addr;
  logic                id_wen;
  logic                id_is_load;
  logic [DW-1:0]       rf_rs_data;
  logic [DW-1:0]       rf_rt_data;
  logic [DEPTH*DW-1:0] stage_data;
  logic                br_taken;
  logic                stall;
  logic                flush;
  logic [DW-1:0]       fwd_rs_data;
  logic [DW-1:0]       fwd_rt_data;
  logic [SW-1:0]       fwd_rs_sel;
  logic [SW-1:0]       fwd_rt_sel;
  logic [CW-1:0]       stall_cnt;
  logic [CW-1:0]       flush_cnt;

  modport master (
    output id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used, id_rd_addr, id_wen,
           id_is_load, rf_rs_data, rf_rt_data, stage_data, br_taken,
    input  stall, flush, fwd_rs_data, fwd_rt_data, fwd_rs_sel, fwd_rt_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs_addr, id_rs_used, id_rt_addr, id_rt_used, id_rd_addr, id_wen,
           id_is_load, rf_rs_data, rf_rt_data, stage_data, br_taken,
    output stall, flush, fwd_rs_data, fwd_rt_data, fwd_rs_sel, fwd_rt_sel, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fwd_match_prio.sv
// Priority match of one source register against the shadow pipeline: the youngest
// (lowest-index) writer wins and supplies the forwarded data.
module fwd_match_prio
  import cpu_pkg::*;
#(
  parameter int unsigned DW       = 16,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned SW       = $clog2(DEPTH + 1)
) (
  input  shadow_entry_t [DEPTH:1] entries_i,
  input  logic [DEPTH*DW-1:0]     stage_data_i,
  input  logic [RD_W-1:0]         src_i,
  input  logic                    used_i,
  input  logic [DW-1:0]           rf_data_i,
  output logic [SW-1:0]           sel_o,
  output logic [DW-1:0]           data_o,
  output logic                    hazard_o
);

  logic src_ok;
  logic found;

  assign src_ok = used_i & ((ZERO_REG == 0) | (src_i != '0));

  // Scan youngest to oldest; the first hit locks the result.
  always_comb begin
    sel_o    = SW'(FWD_RF);
    data_o   = rf_data_i;
    hazard_o = 1'b0;
    found    = 1'b0;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      if (!found && src_ok && entries_i[k].v && entries_i[k].wen && (entries_i[k].rd == src_i)) begin
        found    = 1'b1;
        sel_o    = SW'(FWD_STAGE(k));
        data_o   = stage_data_i[(k-1)*DW +: DW];
        // Load result not produced yet at this stage.
        hazard_o = entries_i[k].ld && (k < LOAD_LAT);
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding: shadow pipeline of in-flight writes, RAW
// forwarding to EX, load-use stall, branch flush and saturating stall/flush counters.
module hazard_fwd_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DW       = DW_DEFAULT,
  parameter int unsigned NREG     = NREG_DEFAULT,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned CW       = 16
) (
  input logic            Clk,
  input logic            Rst,
  hazard_fwd_unit_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned SW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || LOAD_LAT < 1 || LOAD_LAT > DEPTH || AW > RD_W) begin : gen_bad_params
    $error("hazard_fwd_unit: illegal DEPTH/LOAD_LAT/NREG combination");
  end

  shadow_entry_t [DEPTH:1] entry_q, entry_d;
  logic [CW-1:0]           stall_cnt_q, stall_cnt_d;
  logic [CW-1:0]           flush_cnt_q, flush_cnt_d;
  logic                    haz_rs, haz_rt;
  logic                    stall;

  fwd_match_prio #(
    .DW(DW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .SW(SW)
  ) u_match_rs (
    .entries_i   (entry_q),
    .stage_data_i(bus.stage_data),
    .src_i       (RD_W'(bus.id_rs_addr)),
    .used_i      (bus.id_rs_used),
    .rf_data_i   (bus.rf_rs_data),
    .sel_o       (bus.fwd_rs_sel),
    .data_o      (bus.fwd_rs_data),
    .hazard_o    (haz_rs)
  );

  fwd_match_prio #(
    .DW(DW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .SW(SW)
  ) u_match_rt (
    .entries_i   (entry_q),
    .stage_data_i(bus.stage_data),
    .src_i       (RD_W'(bus.id_rt_addr)),
    .used_i      (bus.id_rt_used),
    .rf_data_i   (bus.rf_rt_data),
    .sel_o       (bus.fwd_rt_sel),
    .data_o      (bus.fwd_rt_data),
    .hazard_o    (haz_rt)
  );

  // A taken branch squashes the decode slot, so it also masks any load-use stall.
  assign stall         = bus.id_valid & ~bus.br_taken & (haz_rs | haz_rt);
  assign bus.stall     = stall;
  assign bus.flush     = bus.br_taken;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

  // Shadow pipeline advance; stalled or flushed decode slots enter as bubbles.
  always_comb begin
    entry_d        = '0;
    entry_d[1].v   = bus.id_valid & ~stall & ~bus.br_taken;
    entry_d[1].rd  = RD_W'(bus.id_rd_addr);
    entry_d[1].wen = bus.id_wen;
    entry_d[1].ld  = bus.id_is_load;
    for (int unsigned k = 2; k <= DEPTH; k++) begin
      entry_d[k] = entry_q[k-1];
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CW'(1);
    if (bus.br_taken && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CW'(1);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      entry_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Self-checking bench for hazard_fwd_unit: directed scenarios plus randomized traffic,
// all compared against an instruction-history model of the pipeline.
module tb_hazard_fwd_unit;

  localparam int unsigned DW       = 16;
  localparam int unsigned NREG     = 16;
  localparam int unsigned DEPTH    = 3;
  localparam int unsigned LOAD_LAT = 2;
  localparam int unsigned ZERO_REG = 1;
  localparam int unsigned CW       = 4;
  localparam int unsigned AW       = $clog2(NREG);
  localparam int          CNT_MAX  = (1 << CW) - 1;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hazard_fwd_unit_if #(.DW(DW), .NREG(NREG), .DEPTH(DEPTH), .CW(CW)) bus ();

  hazard_fwd_unit #(
    .DW(DW), .NREG(NREG), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT), .ZERO_REG(ZERO_REG), .CW(CW)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Model: history of what entered EX each cycle, newest first (index age-1).
  typedef struct {
    bit v;
    int rd;
    bit wen;
    bit ld;
  } slot_t;

  slot_t               hist[$];
  int                  stall_m, flush_m;
  logic [DEPTH*DW-1:0] sd_flat;

  int            e_rs_sel, e_rt_sel;
  logic [DW-1:0] e_rs_data, e_rt_data;
  bit            e_stall, e_flush;

  task automatic model_reset();
    slot_t b;
    b.v = 0; b.rd = 0; b.wen = 0; b.ld = 0;
    hist.delete();
    for (int i = 0; i < DEPTH; i++) hist.push_back(b);
    stall_m = 0;
    flush_m = 0;
  endtask

  function automatic void ref_src(input int src, input bit used, input logic [DW-1:0] rf,
                                  output int sel, output logic [DW-1:0] data,
                                  output bit not_ready);
    sel = 0; data = rf; not_ready = 0;
    if (!used || (ZERO_REG != 0 && src == 0)) return;
    // Oldest to youngest, so the youngest writer is the one left standing.
    for (int age = DEPTH; age >= 1; age--) begin
      if (hist[age-1].v && hist[age-1].wen && hist[age-1].rd == src) begin
        sel       = age;
        data      = sd_flat[(age-1)*DW +: DW];
        not_ready = hist[age-1].ld && (age < LOAD_LAT);
      end
    end
  endfunction

  task automatic compute_exp();
    bit nr_rs, nr_rt;
    ref_src(int'(bus.id_rs_addr), bus.id_rs_used, bus.rf_rs_data, e_rs_sel, e_rs_data, nr_rs);
    ref_src(int'(bus.id_rt_addr), bus.id_rt_used, bus.rf_rt_data, e_rt_sel, e_rt_data, nr_rt);
    e_stall = bus.id_valid && !bus.br_taken && (nr_rs || nr_rt);
    e_flush = bus.br_taken;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    compute_exp();
    chk({tag, ".stall"}, 32'(bus.stall), 32'(e_stall));
    chk({tag, ".flush"}, 32'(bus.flush), 32'(e_flush));
    chk({tag, ".rs_sel"}, 32'(bus.fwd_rs_sel), 32'(e_rs_sel));
    chk({tag, ".rs_data"}, 32'(bus.fwd_rs_data), 32'(e_rs_data));
    chk({tag, ".rt_sel"}, 32'(bus.fwd_rt_sel), 32'(e_rt_sel));
    chk({tag, ".rt_data"}, 32'(bus.fwd_rt_data), 32'(e_rt_data));
    chk({tag, ".stall_cnt"}, 32'(bus.stall_cnt), 32'(stall_m));
    chk({tag, ".flush_cnt"}, 32'(bus.flush_cnt), 32'(flush_m));
  endtask

  task automatic settle();
    @(negedge Clk);
  endtask

  // Advance one clock and mirror the edge in the model.
  task automatic tick();
    slot_t n;
    compute_exp();
    @(posedge Clk);
    if (!Rst) begin
      model_reset();
    end else begin
      n.v   = bus.id_valid && !e_stall && !bus.br_taken;
      n.rd  = int'(bus.id_rd_addr);
      n.wen = bus.id_wen;
      n.ld  = bus.id_is_load;
      hist.push_front(n);
      void'(hist.pop_back());
      if (e_stall && stall_m < CNT_MAX) stall_m++;
      if (e_flush && flush_m < CNT_MAX) flush_m++;
    end
    #1;
  endtask

  task automatic set_id(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                        input int rd, input bit wen, input bit ld);
    bus.id_valid   = v;
    bus.id_rs_addr = AW'(rs);
    bus.id_rs_used = rsu;
    bus.id_rt_addr = AW'(rt);
    bus.id_rt_used = rtu;
    bus.id_rd_addr = AW'(rd);
    bus.id_wen     = wen;
    bus.id_is_load = ld;
  endtask

  task automatic set_sd(input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                        input logic [DW-1:0] s3);
    sd_flat        = {s3, s2, s1};
    bus.stage_data = sd_flat;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    bus.br_taken = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    Rst = 1'b1;
  endtask

  initial begin
    model_reset();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    bus.rf_rs_data = '0;
    bus.rf_rt_data = '0;
    bus.br_taken   = 1'b0;
    set_sd(16'h0A01, 16'h0A02, 16'h0A03);

    // No dependency right after reset.
    do_reset();
    set_id(1, 3, 1, 4, 1, 6, 1, 0);
    bus.rf_rs_data = 16'h1111;
    bus.rf_rt_data = 16'h2222;
    settle();
    check_all("nodep");
    chk("nodep.rs_data_k", 32'(bus.fwd_rs_data), 32'h1111);
    chk("nodep.rs_sel_k", 32'(bus.fwd_rs_sel), 0);
    chk("nodep.stall_k", 32'(bus.stall), 0);
    chk("nodep.scnt_k", 32'(bus.stall_cnt), 0);

    // EX forward: ADD R5 then SUB reading R5.
    do_reset();
    set_id(1, 1, 1, 2, 1, 5, 1, 0);
    tick();
    set_id(1, 5, 1, 6, 1, 8, 1, 0);
    set_sd(16'h00A5, 16'h0B0B, 16'h0C0C);
    settle();
    check_all("exfwd");
    chk("exfwd.sel_k", 32'(bus.fwd_rs_sel), 1);
    chk("exfwd.data_k", 32'(bus.fwd_rs_data), 32'h00A5);
    chk("exfwd.stall_k", 32'(bus.stall), 0);

    // Youngest writer wins for rt.
    do_reset();
    set_id(1, 1, 1, 1, 0, 2, 1, 0);
    tick();
    tick();
    set_id(1, 9, 1, 2, 1, 11, 1, 0);
    set_sd(16'h0022, 16'h0002, 16'h0003);
    settle();
    check_all("young");
    chk("young.sel_k", 32'(bus.fwd_rt_sel), 1);
    chk("young.data_k", 32'(bus.fwd_rt_data), 32'h0022);

    // Load-use: one stall cycle, then forward from MEM.
    do_reset();
    set_id(1, 1, 1, 1, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 1, 3, 1, 12, 1, 0);
    set_sd(16'hDEAD, 16'h0777, 16'h0333);
    settle();
    check_all("lduse1");
    chk("lduse1.stall_k", 32'(bus.stall), 1);
    tick();
    settle();
    check_all("lduse2");
    chk("lduse2.stall_k", 32'(bus.stall), 0);
    chk("lduse2.sel_k", 32'(bus.fwd_rs_sel), 2);
    chk("lduse2.data_k", 32'(bus.fwd_rs_data), 32'h0777);
    chk("lduse2.scnt_k", 32'(bus.stall_cnt), 1);

    // Branch beats load-use; the squashed instruction (writes R9) must not enter.
    do_reset();
    set_id(1, 1, 1, 1, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 1, 3, 1, 9, 1, 0);
    bus.br_taken = 1'b1;
    settle();
    check_all("brst");
    chk("brst.flush_k", 32'(bus.flush), 1);
    chk("brst.stall_k", 32'(bus.stall), 0);
    tick();
    bus.br_taken = 1'b0;
    set_id(1, 7, 1, 9, 1, 10, 1, 0);
    settle();
    check_all("brst2");
    chk("brst2.rt_sel_k", 32'(bus.fwd_rt_sel), 0);
    chk("brst2.rs_sel_k", 32'(bus.fwd_rs_sel), 2);
    chk("brst2.fcnt_k", 32'(bus.flush_cnt), 1);

    // Register 0 is never forwarded or stalled on.
    do_reset();
    set_id(1, 1, 1, 1, 0, 0, 1, 0);
    tick();
    set_id(1, 1, 1, 1, 0, 0, 1, 1);
    tick();
    set_id(1, 0, 1, 0, 1, 4, 1, 0);
    settle();
    check_all("zero");
    chk("zero.rs_sel_k", 32'(bus.fwd_rs_sel), 0);
    chk("zero.rt_sel_k", 32'(bus.fwd_rt_sel), 0);
    chk("zero.stall_k", 32'(bus.stall), 0);

    // Back-to-back dependent loads stall every other cycle; counter must saturate.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      set_id(1, 7, 1, 7, 1, 7, 1, 1);
      settle();
      check_all("satst");
      tick();
    end
    chk("satst.scnt_k", 32'(bus.stall_cnt), CNT_MAX);
    bus.br_taken = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    bus.br_taken = 1'b0;
    settle();
    chk("satfl.fcnt_k", 32'(bus.flush_cnt), CNT_MAX);

    // Randomized traffic with occasional resets.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      Rst = ($urandom_range(0, 49) != 0);
      set_id($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 1),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      bus.br_taken   = ($urandom_range(0, 9) == 0);
      bus.rf_rs_data = DW'($urandom);
      bus.rf_rt_data = DW'($urandom);
      set_sd(DW'($urandom), DW'($urandom), DW'($urandom));
      settle();
      check_all("rand");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
